vip_bit_bbox_detector: RTL and testbench
========================================

Name: vip_bit_bbox_detector

Overview:
- Sits directly downstream of the 1-bit erosion detector. Consumes its eroded binary pixel stream (vsync/href/clken/bit).
- Accumulates per frame the bounding box and pixel count of foreground (bit=1) pixels. Publishes the result at frame end.
- Re-emits the stream 1 cycle later with the previous frame's box drawn as a 1-pixel border, for display and debug.

Parameters:
- IMG_HDISP, 640, active pixels per line.
- IMG_VDISP, 480, active lines per frame.
- XW, 10, column coordinate width (must satisfy 2^XW >= IMG_HDISP).
- YW, 10, row coordinate width (must satisfy 2^YW >= IMG_VDISP).
- CNTW, 20, foreground pixel counter width.
- MIN_PIXELS, 64, minimum foreground count for a box to be declared valid.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- per_frame_vsync  in  1  high for the whole frame.
- per_frame_href  in  1  high during an active line.
- per_frame_clken  in  1  pixel strobe.
- per_img_Bit  in  1  eroded pixel, 1 = foreground.
- overlay_en  in  1  enables border drawing on the output.
- post_frame_vsync  out  1  per_frame_vsync delayed 1 cycle.
- post_frame_href  out  1  per_frame_href delayed 1 cycle.
- post_frame_clken  out  1  per_frame_clken delayed 1 cycle.
- post_img_Bit  out  1  pixel OR border, forced 0 when post_frame_href=0.
- box_valid  out  1  last completed frame had count >= MIN_PIXELS.
- box_xmin  out  XW  left column of the box.
- box_xmax  out  XW  right column of the box.
- box_ymin  out  YW  top row of the box.
- box_ymax  out  YW  bottom row of the box.
- box_count  out  CNTW  foreground pixel count of the last completed frame.
- box_update  out  1  1-cycle pulse when the box outputs are reloaded.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0, accumulators at their init values.
- Edge detect: vsync_r and href_r are registered copies of the inputs.
  - vs_rise = vsync & ~vsync_r; vs_fall = ~vsync & vsync_r; href_fall = ~href & href_r.
- FSM states and transitions:
  - IDLE: wait for vs_rise, then go to ACTIVE and clear col, row and count.
  - Accumulator init value: xmin/ymin = all-ones, xmax/ymax = 0.
  - ACTIVE: on vs_fall go to LATCH. A pixel that arrives in the vs_fall cycle is ignored, because vsync is already low.
  - LATCH (1 cycle): load outputs, then go to IDLE.
- Counting:
  - col increments on each clken with href=1; col clears on href_fall.
  - row increments on href_fall and clears on vs_rise.
  - Pixels with col >= IMG_HDISP or row >= IMG_VDISP are not accumulated. col and row saturate at all-ones and never wrap.
- Accumulate: when ACTIVE, clken, href and bit are all 1 and the pixel is in range:
  - update the min/max of col and row;
  - count saturating-increments at 2^CNTW-1.
- LATCH load:
  - count >= MIN_PIXELS: box_valid=1, box_x/y take the accumulators, box_count=count.
  - Otherwise: box_valid=0, coordinates=0, box_count=count.
  - box_update=1 for exactly that one registered cycle.
  - Timing: if cycle N is the first cycle with vsync sampled low, new outputs and box_update are visible in cycle N+2.
- Overlay (1-cycle pipeline):
  - border = overlay_en & box_valid & in_box_edge.
  - in_box_edge = (col==xmin or col==xmax) with row in [ymin,ymax], or (row==ymin or row==ymax) with col in [xmin,xmax].
  - The comparison uses the currently published box, i.e. the previous frame's box.
  - post_img_Bit = href_d ? (bit_d | border_d) : 0.
  - The published box is stable during the next frame because LATCH occurs during vertical blanking.
- Reset mid-frame: the partial frame is discarded; the block resynchronises on the next vs_rise.
- A vs_rise in LATCH is impossible for legal video (blanking lasts more than 2 cycles). If it occurs, LATCH still completes and the frame start is missed.

Decomposition:
- Shared package vip_pkg holds:
  - the state enum {IDLE, ACTIVE, LATCH};
  - default IMG_HDISP/IMG_VDISP constants shared with the matrix generator and erosion stages.
- One natural sub-module, vip_frame_pos_counter: edge detect plus col/row counters with saturation. It is reusable by the other VIP stages.

Test Plan:
- 8x6 frame (IMG_HDISP=8, IMG_VDISP=6, MIN_PIXELS=1), a single pixel at col 3 row 2 -> box_valid=1, xmin=xmax=3, ymin=ymax=2, count=1, box_update at N+2.
- 8x6 frame, foreground block cols 2..5, rows 1..4 (16 px) -> box (2,5,1,4), count=16. Next frame with overlay_en=1 and an all-zero input -> post_img_Bit=1 exactly on the 12 border pixels.
- All-zero frame after a valid frame -> box_valid=0, coordinates 0, count 0, box_update pulses once.
- MIN_PIXELS=4 and 3 foreground pixels -> box_valid=0, count=3. Adding a 4th pixel -> box_valid=1.
- Assert rst for 1 cycle mid-frame after 5 foreground pixels -> outputs 0, no box_update for that frame. The next full frame reports correctly.
- Line with 10 clken pulses and IMG_HDISP=8, foreground at pulses 9–10 -> ignored, count unchanged. A pixel coincident with vs_fall is not counted.

Source files
------------

// File: rtl/vip_pkg.sv
// Definitions shared by the VIP pixel-pipeline stages: the frame-tracking FSM
// state encoding and the default active-image geometry.
package vip_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    LATCH  = 2'd2
  } vip_state_t;

  localparam int VIP_IMG_HDISP = 640;
  localparam int VIP_IMG_VDISP = 480;

endpackage

// File: rtl/vip_frame_pos_counter.sv
// Sync edge detection and saturating column/row position counters for a
// vsync/href/clken pixel stream.
module vip_frame_pos_counter #(
  parameter int XW = 10,
  parameter int YW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          href,
  input  logic          clken,
  output logic          vs_rise,
  output logic          vs_fall,
  output logic          href_fall,
  output logic [XW-1:0] col,
  output logic [YW-1:0] row
);

  logic vsync_r;
  logic href_r;

  // Edge registers follow the inputs even through reset, so deasserting reset
  // in the middle of a frame cannot look like a frame start.
  always_ff @(posedge clk) begin
    vsync_r <= vsync;
    href_r  <= href;
  end

  assign vs_rise   = vsync & ~vsync_r;
  assign vs_fall   = ~vsync & vsync_r;
  assign href_fall = ~href & href_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else begin
      if (vs_rise || href_fall)
        col <= '0;
      else if (clken && href && (col != '1))
        col <= col + 1'b1;

      if (vs_rise)
        row <= '0;
      else if (href_fall && (row != '1))
        row <= row + 1'b1;
    end
  end

endmodule

// File: rtl/vip_bit_bbox_detector.sv
// Per-frame bounding box and foreground count of a binary pixel stream, with
// the previously published box drawn as a border on the re-emitted stream.
module vip_bit_bbox_detector
  import vip_pkg::*;
#(
  parameter int IMG_HDISP  = VIP_IMG_HDISP,
  parameter int IMG_VDISP  = VIP_IMG_VDISP,
  parameter int XW         = 10,
  parameter int YW         = 10,
  parameter int CNTW       = 20,
  parameter int MIN_PIXELS = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            per_frame_vsync,
  input  logic            per_frame_href,
  input  logic            per_frame_clken,
  input  logic            per_img_Bit,
  input  logic            overlay_en,
  output logic            post_frame_vsync,
  output logic            post_frame_href,
  output logic            post_frame_clken,
  output logic            post_img_Bit,
  output logic            box_valid,
  output logic [XW-1:0]   box_xmin,
  output logic [XW-1:0]   box_xmax,
  output logic [YW-1:0]   box_ymin,
  output logic [YW-1:0]   box_ymax,
  output logic [CNTW-1:0] box_count,
  output logic            box_update
);

  localparam logic [XW:0]     H_LIM   = (XW+1)'(IMG_HDISP);
  localparam logic [YW:0]     V_LIM   = (YW+1)'(IMG_VDISP);
  localparam logic [CNTW-1:0] MIN_LIM = CNTW'(MIN_PIXELS);

  logic            vs_rise, vs_fall, href_fall;
  logic [XW-1:0]   col;
  logic [YW-1:0]   row;

  vip_state_t      state_reg, state_next;
  logic            frame_start, latch_load;
  logic [CNTW-1:0] count_reg;
  logic [XW-1:0]   xmin_reg, xmax_reg;
  logic [YW-1:0]   ymin_reg, ymax_reg;
  logic            in_range, pix_hit;
  logic            col_edge, row_edge, border;
  logic            bit_d, border_d;

  vip_frame_pos_counter #(.XW(XW), .YW(YW)) u_pos (
    .clk       (clk),
    .rst       (rst),
    .vsync     (per_frame_vsync),
    .href      (per_frame_href),
    .clken     (per_frame_clken),
    .vs_rise   (vs_rise),
    .vs_fall   (vs_fall),
    .href_fall (href_fall),
    .col       (col),
    .row       (row)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    frame_start = 1'b0;
    latch_load  = 1'b0;
    case (state_reg)
      IDLE:    if (vs_rise) begin
                 state_next  = ACTIVE;
                 frame_start = 1'b1;
               end
      ACTIVE:  if (vs_fall) state_next = LATCH;
      LATCH:   begin
                 latch_load = 1'b1;
                 state_next = IDLE;
               end
      default: state_next = IDLE;
    endcase
  end

  // Requiring vsync high drops a pixel that coincides with the end of frame.
  assign in_range = ({1'b0, col} < H_LIM) && ({1'b0, row} < V_LIM);
  assign pix_hit  = (state_reg == ACTIVE) && per_frame_vsync && per_frame_href &&
                    per_frame_clken && per_img_Bit && in_range;

  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      count_reg <= '0;
      xmin_reg  <= '1;
      xmax_reg  <= '0;
      ymin_reg  <= '1;
      ymax_reg  <= '0;
    end else if (pix_hit) begin
      if (count_reg != '1) count_reg <= count_reg + 1'b1;
      if (col < xmin_reg)  xmin_reg  <= col;
      if (col > xmax_reg)  xmax_reg  <= col;
      if (row < ymin_reg)  ymin_reg  <= row;
      if (row > ymax_reg)  ymax_reg  <= row;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      box_valid  <= 1'b0;
      box_xmin   <= '0;
      box_xmax   <= '0;
      box_ymin   <= '0;
      box_ymax   <= '0;
      box_count  <= '0;
      box_update <= 1'b0;
    end else begin
      box_update <= latch_load;
      if (latch_load) begin
        box_count <= count_reg;
        if (count_reg >= MIN_LIM) begin
          box_valid <= 1'b1;
          box_xmin  <= xmin_reg;
          box_xmax  <= xmax_reg;
          box_ymin  <= ymin_reg;
          box_ymax  <= ymax_reg;
        end else begin
          box_valid <= 1'b0;
          box_xmin  <= '0;
          box_xmax  <= '0;
          box_ymin  <= '0;
          box_ymax  <= '0;
        end
      end
    end
  end

  // Border is drawn from the published box, which is frozen while a frame streams.
  assign col_edge = ((col == box_xmin) || (col == box_xmax)) &&
                    (row >= box_ymin) && (row <= box_ymax);
  assign row_edge = ((row == box_ymin) || (row == box_ymax)) &&
                    (col >= box_xmin) && (col <= box_xmax);
  assign border   = overlay_en & box_valid & (col_edge | row_edge);

  always_ff @(posedge clk) begin
    if (rst) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      bit_d            <= 1'b0;
      border_d         <= 1'b0;
    end else begin
      post_frame_vsync <= per_frame_vsync;
      post_frame_href  <= per_frame_href;
      post_frame_clken <= per_frame_clken;
      bit_d            <= per_img_Bit;
      border_d         <= border;
    end
  end

  assign post_img_Bit = post_frame_href & (bit_d | border_d);

endmodule

// File: tb/tb_vip_bit_bbox_detector.sv
// Randomised and directed frames on an 8x6 image into two detectors (MIN_PIXELS
// 1 and 4), checked every cycle against a frame-level reference model.
module tb_vip_bit_bbox_detector;

  localparam int H = 8;
  localparam int V = 6;
  localparam int MIN0 = 1;
  localparam int MIN1 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vsync = 1'b0, href = 1'b0, clken = 1'b0, bitv = 1'b0, ov_en = 1'b0;
  int   cur_col = 0, cur_row = 0;

  logic        p_vs [2], p_hr [2], p_ck [2], p_bit [2];
  logic        b_valid [2], b_upd [2];
  logic [3:0]  b_xmin [2], b_xmax [2], b_ymin [2], b_ymax [2];
  logic [19:0] b_cnt [2];

  always #5 clk = ~clk;

  vip_bit_bbox_detector #(.IMG_HDISP(H), .IMG_VDISP(V), .XW(4), .YW(4), .CNTW(20),
                          .MIN_PIXELS(MIN0)) u_dut0 (
    .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href),
    .per_frame_clken(clken), .per_img_Bit(bitv), .overlay_en(ov_en),
    .post_frame_vsync(p_vs[0]), .post_frame_href(p_hr[0]), .post_frame_clken(p_ck[0]),
    .post_img_Bit(p_bit[0]), .box_valid(b_valid[0]), .box_xmin(b_xmin[0]),
    .box_xmax(b_xmax[0]), .box_ymin(b_ymin[0]), .box_ymax(b_ymax[0]),
    .box_count(b_cnt[0]), .box_update(b_upd[0])
  );

  vip_bit_bbox_detector #(.IMG_HDISP(H), .IMG_VDISP(V), .XW(4), .YW(4), .CNTW(20),
                          .MIN_PIXELS(MIN1)) u_dut1 (
    .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href),
    .per_frame_clken(clken), .per_img_Bit(bitv), .overlay_en(ov_en),
    .post_frame_vsync(p_vs[1]), .post_frame_href(p_hr[1]), .post_frame_clken(p_ck[1]),
    .post_img_Bit(p_bit[1]), .box_valid(b_valid[1]), .box_xmin(b_xmin[1]),
    .box_xmax(b_xmax[1]), .box_ymin(b_ymin[1]), .box_ymax(b_ymax[1]),
    .box_count(b_cnt[1]), .box_update(b_upd[1])
  );

  int checks = 0, passes = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Frame-level model: the driver accumulates what the frame should report.
  bit img [16][16];
  bit frame_ok = 0;
  int f_cnt, f_xmin, f_xmax, f_ymin, f_ymax;

  // Published-box model and per-cycle expectations, owned by the compare process.
  logic        pv [2], pu [2];
  logic [3:0]  px0 [2], px1 [2], py0 [2], py1 [2];
  logic [19:0] pc [2];
  logic [3:0]  exp_post [2];
  int          cyc = 0, sched = -1;
  bit          armed = 0, vs_prev = 0;
  int          ones0 = 0;
  int          upd_seen [2] = '{0, 0};

  always @(negedge clk) begin
    logic brd;
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        chk(k ? "post1" : "post0", {p_vs[k], p_hr[k], p_ck[k], p_bit[k]}, exp_post[k]);
        chk(k ? "box1" : "box0",
            {b_valid[k], b_xmin[k], b_xmax[k], b_ymin[k], b_ymax[k], b_cnt[k], b_upd[k]},
            {pv[k], px0[k], px1[k], py0[k], py1[k], pc[k], pu[k]});
        if (b_upd[k]) upd_seen[k]++;
      end
      if (p_bit[0]) ones0++;
    end
    cyc++;
    if (rst) begin
      armed = 1;
      sched = -1;
      for (int k = 0; k < 2; k++) begin
        exp_post[k] = 4'b0;
        {pv[k], px0[k], px1[k], py0[k], py1[k], pc[k], pu[k]} = '0;
      end
    end else begin
      if (!vsync && vs_prev && frame_ok) sched = cyc + 2;
      for (int k = 0; k < 2; k++) begin
        // The pixel lies on the perimeter of the published rectangle.
        brd = ov_en && pv[k] &&
              (((cur_col == px0[k] || cur_col == px1[k]) && cur_row >= py0[k] && cur_row <= py1[k]) ||
               ((cur_row == py0[k] || cur_row == py1[k]) && cur_col >= px0[k] && cur_col <= px1[k]));
        exp_post[k] = {vsync, href, clken, href & (bitv | brd)};
        pu[k] = (cyc + 1 == sched);
        if (pu[k]) begin
          pc[k] = 20'(f_cnt);
          pv[k] = (f_cnt >= (k ? MIN1 : MIN0));
          px0[k] = pv[k] ? 4'(f_xmin) : 4'd0;
          px1[k] = pv[k] ? 4'(f_xmax) : 4'd0;
          py0[k] = pv[k] ? 4'(f_ymin) : 4'd0;
          py1[k] = pv[k] ? 4'(f_ymax) : 4'd0;
        end
      end
    end
    vs_prev = vsync;
  end

  task automatic cyc_drive(input logic r, v, h, c, b, input int x, y);
    @(posedge clk);
    #1;
    rst = r; vsync = v; href = h; clken = c; bitv = b; cur_col = x; cur_row = y;
    if (frame_ok && !r && v && h && c && b && x < H && y < V) begin
      f_cnt++;
      if (x < f_xmin) f_xmin = x;
      if (x > f_xmax) f_xmax = x;
      if (y < f_ymin) f_ymin = y;
      if (y > f_ymax) f_ymax = y;
    end
  endtask

  task automatic run_frame(input int nl, np, input bit gaps, fallp, ov, input int rst_after);
    frame_ok = 1;
    f_cnt = 0; f_xmin = 15; f_xmax = 0; f_ymin = 15; f_ymax = 0;
    ov_en = ov;
    repeat (2) cyc_drive(0, 1, 0, 0, 0, 0, 0);
    for (int y = 0; y < nl; y++) begin
      for (int x = 0; x < np; x++) begin
        if (gaps && $urandom_range(0, 3) == 0)
          cyc_drive(0, 1, 1, 0, 1'($urandom_range(0, 1)), x, y);
        cyc_drive(0, 1, 1, 1, img[y][x], x, y);
        if (rst_after > 0 && frame_ok && f_cnt == rst_after) begin
          frame_ok = 0;
          cyc_drive(1, 1, 1, 0, 0, x + 1, y);
        end
      end
      repeat (3) cyc_drive(0, 1, 0, 0, 0, 0, y + 1);
    end
    if (fallp) cyc_drive(0, 0, 1, 1, 1, 0, nl);
    else       cyc_drive(0, 0, 0, 0, 0, 0, nl);
    repeat (6) cyc_drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_img();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) img[y][x] = 0;
  endtask

  initial begin
    int u0, u1, o0;
    clear_img();
    repeat (3) cyc_drive(1, 0, 0, 0, 0, 0, 0);
    cyc_drive(0, 0, 0, 0, 0, 0, 0);
    #4;
    chk("reset_state", {b_valid[0], b_cnt[0], b_upd[0], p_bit[0]}, 23'd0);

    // Single foreground pixel at col 3, row 2.
    img[2][3] = 1;
    u0 = upd_seen[0];
    run_frame(6, 8, 0, 0, 0, -1);
    chk("single_box", {b_valid[0], b_xmin[0], b_xmax[0], b_ymin[0], b_ymax[0], b_cnt[0]},
        {1'b1, 4'd3, 4'd3, 4'd2, 4'd2, 20'd1});
    chk("single_min4", {b_valid[1], b_cnt[1]}, {1'b0, 20'd1});
    chk("single_upd", upd_seen[0] - u0, 1);

    // 4x4 block, cols 2..5 rows 1..4, with clken gaps.
    clear_img();
    for (int y = 1; y <= 4; y++)
      for (int x = 2; x <= 5; x++) img[y][x] = 1;
    run_frame(6, 8, 1, 0, 0, -1);
    chk("block_box", {b_valid[0], b_xmin[0], b_xmax[0], b_ymin[0], b_ymax[0], b_cnt[0]},
        {1'b1, 4'd2, 4'd5, 4'd1, 4'd4, 20'd16});
    chk("block_min4", b_valid[1], 1);

    // All-zero frame with overlay: only the 12 border pixels appear.
    clear_img();
    o0 = ones0; u0 = upd_seen[0];
    run_frame(6, 8, 0, 0, 1, -1);
    chk("border_pixels", ones0 - o0, 12);
    chk("empty_box", {b_valid[0], b_xmin[0], b_xmax[0], b_ymin[0], b_ymax[0], b_cnt[0]}, 37'd0);
    chk("empty_upd", upd_seen[0] - u0, 1);

    // Threshold 4: three pixels then four.
    img[0][0] = 1; img[5][7] = 1; img[3][4] = 1;
    run_frame(6, 8, 0, 0, 0, -1);
    chk("three_min4", {b_valid[1], b_cnt[1]}, {1'b0, 20'd3});
    chk("three_box", {b_valid[0], b_xmin[0], b_xmax[0], b_ymin[0], b_ymax[0]},
        {1'b1, 4'd0, 4'd7, 4'd0, 4'd5});
    img[1][2] = 1;
    run_frame(6, 8, 0, 0, 0, -1);
    chk("four_min4", {b_valid[1], b_cnt[1]}, {1'b1, 20'd4});

    // Reset after 5 foreground pixels: frame discarded, next frame reported.
    clear_img();
    for (int y = 1; y <= 4; y++)
      for (int x = 2; x <= 5; x++) img[y][x] = 1;
    u0 = upd_seen[0]; u1 = upd_seen[1];
    run_frame(6, 8, 0, 0, 1, 5);
    chk("rst_outputs", {b_valid[0], b_cnt[0], b_valid[1], b_cnt[1]}, 42'd0);
    chk("rst_no_upd", (upd_seen[0] - u0) + (upd_seen[1] - u1), 0);
    run_frame(6, 8, 0, 0, 1, -1);
    chk("after_rst_cnt", b_cnt[0], 16);

    // 10 pulses per line: pulses 9-10 out of range; a pixel on vsync fall.
    clear_img();
    img[0][8] = 1; img[0][9] = 1; img[1][1] = 1;
    run_frame(5, 10, 0, 1, 0, -1);
    chk("overrun_cnt", {b_valid[0], b_cnt[0]}, {1'b1, 20'd1});

    // Randomised frames.
    for (int f = 0; f < 20; f++) begin
      for (int y = 0; y < 16; y++)
        for (int x = 0; x < 16; x++) img[y][x] = ($urandom_range(0, 99) < 8 * (f % 5));
      run_frame($urandom_range(4, 7), $urandom_range(8, 10), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
